// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: mono I2S transmitter for the board codec DAC.
//
// Takes 16-bit two's-complement samples from the wave generator over a
// valid/ready handshake and serializes each sample MSB-first into both the
// left and right slot of an I2S frame. BCLK and LRCLK are generated here;
// the codec runs as clock slave. Serial outputs change only when BCLK falls,
// so the codec can sample them on the rising edge.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   sample_in    two's-complement sample
//   sample_valid sample_in is valid
//   sample_ready sample storage can take a sample
//   i2s_bclk     bit clock, period 2*BCLK_DIV clk
//   i2s_lrclk    word select, 0 = left, 1 = right
//   i2s_dacdat   serial data
//   frame_start  one-clk pulse when a sample is loaded into the shifter
//   underrun     one-clk pulse when a frame starts with no new sample
//   fifo_level   entry count (only with I2S_DAC_TX_FIFO_EN)
//
// Build option: define I2S_DAC_TX_FIFO_EN to replace the single holding
// register with a 4-entry FIFO and expose fifo_level.

module i2s_dac_tx #(
    parameter int BCLK_DIV  = 8,
    parameter int SLOT_BITS = 32,
    parameter int DATA_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              i2s_bclk,
    output logic              i2s_lrclk,
    output logic              i2s_dacdat,
    output logic              frame_start,
    output logic              underrun
`ifdef I2S_DAC_TX_FIFO_EN
    ,
    output logic [2:0]        fifo_level
`endif
);

    localparam int FRAME  = 2 * SLOT_BITS;
    localparam int BW     = $clog2(FRAME);
    localparam int CNT_W  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(BCLK_DIV - 1);
    localparam logic [BW-1:0]    BIT_LAST = BW'(FRAME - 1);
    localparam logic [BW-1:0]    SLOT_V   = BW'(SLOT_BITS);
    localparam logic [BW-1:0]    DATA_V   = BW'(DATA_W);

    logic [CNT_W-1:0]  div_cnt;
    logic              div_wrap;
    logic              fall_evt;
    logic              frame_evt;
    logic [BW-1:0]     bit_cnt;
    logic [BW-1:0]     bit_nxt;
    logic [BW-1:0]     pos;
    logic [DATA_W-1:0] shifter;
    logic [DATA_W-1:0] last_sample;
    logic [DATA_W-1:0] shifted;
    logic              data_bit;
    logic              accept;

    // Sample storage interface: load_ok says a fresh sample is available
    // at frame start, load_data is that sample.
    logic              load_ok;
    logic [DATA_W-1:0] load_data;

    assign div_wrap = (div_cnt == DIV_LAST);
    assign fall_evt = div_wrap & i2s_bclk;
    assign accept   = sample_valid & sample_ready;

    // Bit position that becomes current at this fall event, and the data
    // bit to launch for it. Position 0 of each slot is the I2S one-bit delay.
    always_comb begin
        bit_nxt   = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        pos       = (bit_nxt >= SLOT_V) ? bit_nxt - SLOT_V : bit_nxt;
        frame_evt = fall_evt && (bit_nxt == '0);
        shifted   = shifter >> (DATA_V - pos);
        data_bit  = ((pos != '0) && (pos <= DATA_V)) ? shifted[0] : 1'b0;
    end

`ifdef I2S_DAC_TX_FIFO_EN
    logic [DATA_W-1:0] fifo_mem [4];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [2:0]        count;
    logic              push;
    logic              pop;

    assign push         = accept;
    assign pop          = frame_evt & load_ok;
    assign load_ok      = (count != 3'd0);
    assign load_data    = fifo_mem[rd_ptr];
    assign sample_ready = (count != 3'd4);
    assign fifo_level   = count;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Push and pop together leave the count unchanged.
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
`else
    logic [DATA_W-1:0] holding;
    logic              full;

    assign load_ok      = full;
    assign load_data    = holding;
    assign sample_ready = ~full;

    // An accept can only happen while empty, so it never collides with a
    // frame-start load; an accept in a frame-start cycle with the register
    // empty fills it for the following frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            holding <= '0;
            full    <= 1'b0;
        end else begin
            if (frame_evt && full) begin
                full <= 1'b0;
            end
            if (accept) begin
                holding <= sample_in;
                full    <= 1'b1;
            end
        end
    end
`endif

    // Clock generation, slot sequencing and serializer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            i2s_bclk    <= 1'b0;
            bit_cnt     <= BIT_LAST;
            i2s_lrclk   <= 1'b0;
            i2s_dacdat  <= 1'b0;
            shifter     <= '0;
            last_sample <= '0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
            if (div_wrap) begin
                i2s_bclk <= ~i2s_bclk;
            end

            frame_start <= frame_evt;
            underrun    <= frame_evt & ~load_ok;

            if (fall_evt) begin
                bit_cnt    <= bit_nxt;
                i2s_lrclk  <= (bit_nxt >= SLOT_V);
                i2s_dacdat <= data_bit;
            end

            // With no fresh sample the previous one is repeated so the DAC
            // holds its level instead of dropping to zero.
            if (frame_evt) begin
                if (load_ok) begin
                    shifter     <= load_data;
                    last_sample <= load_data;
                end else begin
                    shifter <= last_sample;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_dac_tx.sv
module tb_i2s_dac_tx;

    localparam int D     = 2;
    localparam int SLOT  = 32;
    localparam int FRAME = 2 * SLOT;
    localparam int DW    = 16;
    localparam int FCLK  = 2 * D * FRAME;
`ifdef I2S_DAC_TX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] sample_in;
    logic          sample_valid;
    logic          sample_ready;
    logic          i2s_bclk;
    logic          i2s_lrclk;
    logic          i2s_dacdat;
    logic          frame_start;
    logic          underrun;
`ifdef I2S_DAC_TX_FIFO_EN
    logic [2:0]    fifo_level;
`endif

    always #5 clk = ~clk;

    i2s_dac_tx #(
        .BCLK_DIV (D),
        .SLOT_BITS(SLOT),
        .DATA_W   (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrclk   (i2s_lrclk),
        .i2s_dacdat  (i2s_dacdat),
        .frame_start (frame_start),
        .underrun    (underrun)
`ifdef I2S_DAC_TX_FIFO_EN
        ,
        .fifo_level  (fifo_level)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: time since reset in clk edges, a queue of accepted
    // samples, and the word being transmitted in the current frame.
    int            k;
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_word, m_last;
    logic          m_ready, m_fs, m_ur, m_bclk, m_lr, m_dat, m_acc;

    logic [5:0] dut_vec;
    logic [5:0] exp_vec;
    assign dut_vec = {i2s_bclk, i2s_lrclk, i2s_dacdat, frame_start, underrun, sample_ready};
    assign exp_vec = {m_bclk, m_lr, m_dat, m_fs, m_ur, m_ready};

    function automatic int fall_bit(input int kk);
        if (kk <= 0 || (kk % (2 * D)) != 0) return -1;
        return (kk / (2 * D) - 1) % FRAME;
    endfunction

    function automatic int frame_idx(input int kk);
        if (kk < 2 * D) return -1;
        return (kk / (2 * D) - 1) / FRAME;
    endfunction

    task automatic model_reset();
        k = 0; q.delete(); m_word = '0; m_last = '0;
        m_ready = 1'b1; m_fs = 1'b0; m_ur = 1'b0;
        m_bclk = 1'b0; m_lr = 1'b0; m_dat = 1'b0; m_acc = 1'b0;
    endtask

    task automatic do_reset();
        sample_valid = 1'b0;
        sample_in    = '0;
        rst_n        = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        model_reset();
    endtask

    // Advance one clk edge and update the model; returns 1 time unit later.
    task automatic step();
        logic          v;
        logic [DW-1:0] d;
        logic          rdy;
        int            m, b, p;
        v = sample_valid; d = sample_in; rdy = m_ready;
        @(posedge clk);
        k++;
        m_fs = 1'b0; m_ur = 1'b0;
        if (fall_bit(k) == 0) begin
            m_fs = 1'b1;
            if (q.size() > 0) begin
                m_word = q.pop_front();
                m_last = m_word;
            end else begin
                m_word = m_last;
                m_ur   = 1'b1;
            end
        end
        m_acc = v && rdy;
        if (m_acc) q.push_back(d);
        m_ready = (q.size() < CAP);
        m_bclk  = ((k / D) % 2) == 1;
        m = k / (2 * D);
        if (m == 0) begin
            m_lr = 1'b0; m_dat = 1'b0;
        end else begin
            b = (m - 1) % FRAME;
            m_lr = (b >= SLOT);
            p = b % SLOT;
            m_dat = (p >= 1 && p <= DW) ? m_word[DW - p] : 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; sample_valid = 1'b0; sample_in = '0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dut_vec !== 6'b000001) begin
            n_fail++;
            $display("FAIL reset_state got %b want 000001 (bclk,lr,dat,fs,ur,rdy)", dut_vec);
        end
`ifdef I2S_DAC_TX_FIFO_EN
        n_checks++;
        if (fifo_level !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_fifo_level got %0d want 0", fifo_level);
        end
`endif
        do_reset();
        n_checks++;
        if (dut_vec !== 6'b000001) begin
            n_fail++;
            $display("FAIL post_release got %b want 000001", dut_vec);
        end
    endtask

    task automatic test_idle();
        int urs = 0;
        do_reset();
        for (int i = 0; i < 2 * FCLK + 8; i++) begin
            step();
            if (underrun === 1'b1) urs++;
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                if (n_fail <= 40) $display("FAIL idle k=%0d got %b want %b", k, dut_vec, exp_vec);
            end
        end
        n_checks++;
        if (urs != 3) begin
            n_fail++;
            $display("FAIL idle_underrun_count got %0d want 3", urs);
        end
    endtask

    task automatic test_first_sample();
        logic [FRAME-1:0] cap = '0;
        logic [FRAME-1:0] want;
        int b;
        want = {1'b0, 16'hA5C3, 15'd0, 1'b0, 16'hA5C3, 15'd0};
        do_reset();
        sample_in = 16'hA5C3; sample_valid = 1'b1;
        while (k < 2 * D + FCLK + 4) begin
            step();
            sample_valid = 1'b0;
            b = fall_bit(k);
            if (b >= 0 && frame_idx(k) == 0) cap[FRAME - 1 - b] = i2s_dacdat;
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                if (n_fail <= 40) $display("FAIL first_sample k=%0d got %b want %b", k, dut_vec, exp_vec);
            end
            if (k == 2 * D) begin
                n_checks++;
                if ({frame_start, underrun} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL first_frame_flags got fs,ur=%b want 10", {frame_start, underrun});
                end
            end
            if (k == 2 * D + 1) begin
                n_checks++;
                if (sample_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ready_after_load got %b want 1", sample_ready);
                end
            end
        end
        n_checks++;
        if (cap !== want) begin
            n_fail++;
            $display("FAIL first_frame_bits got %h want %h", cap, want);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] cap2 = '0;
        int b;
        do_reset();
        sample_in = 16'h8001; sample_valid = 1'b1;
        step();
        sample_in = 16'h1234;
        while (k < 3 * FCLK) begin
            if (k > 1 && m_acc) sample_valid = 1'b0;
            step();
            b = fall_bit(k);
            if (b >= 1 && b <= DW && frame_idx(k) == 1) cap2[DW - b] = i2s_dacdat;
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                if (n_fail <= 40) $display("FAIL back_to_back k=%0d got %b want %b", k, dut_vec, exp_vec);
            end
        end
        n_checks++;
        if (cap2 !== 16'h1234) begin
            n_fail++;
            $display("FAIL second_frame_word got %h want 1234", cap2);
        end
    endtask

    task automatic test_starve();
        logic [DW-1:0] cap2 = '0;
        int urs = 0;
        int b;
        do_reset();
        sample_in = 16'h7FFF; sample_valid = 1'b1;
        while (k < 3 * FCLK) begin
            step();
            sample_valid = 1'b0;
            if (k > 2 * D && k <= 2 * FCLK && underrun === 1'b1) urs++;
            b = fall_bit(k);
            if (b >= 1 && b <= DW && frame_idx(k) == 1) cap2[DW - b] = i2s_dacdat;
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                if (n_fail <= 40) $display("FAIL starve k=%0d got %b want %b", k, dut_vec, exp_vec);
            end
        end
        n_checks++;
        if (urs != 1) begin
            n_fail++;
            $display("FAIL starve_underrun_cycles got %0d want 1", urs);
        end
        n_checks++;
        if (cap2 !== 16'h7FFF) begin
            n_fail++;
            $display("FAIL starve_repeat_word got %h want 7fff", cap2);
        end
    endtask

    task automatic test_fs_accept();
        logic [DW-1:0] cap1 = '0;
        logic [DW-1:0] cap2 = '0;
        int b;
        do_reset();
        sample_in = 16'h1111; sample_valid = 1'b1;
        while (k < 4 * FCLK) begin
            if (k == 2 * D + FCLK - 1) begin
                sample_in = 16'h2222; sample_valid = 1'b1;
            end
            step();
            sample_valid = 1'b0;
            b = fall_bit(k);
            if (b >= 1 && b <= DW && frame_idx(k) == 1) cap1[DW - b] = i2s_dacdat;
            if (b >= 1 && b <= DW && frame_idx(k) == 2) cap2[DW - b] = i2s_dacdat;
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                if (n_fail <= 40) $display("FAIL fs_accept k=%0d got %b want %b", k, dut_vec, exp_vec);
            end
            if (k == 2 * D + FCLK) begin
                n_checks++;
                if ({frame_start, underrun} !== 2'b11) begin
                    n_fail++;
                    $display("FAIL fs_accept_flags got fs,ur=%b want 11", {frame_start, underrun});
                end
            end
        end
        n_checks++;
        if (cap1 !== 16'h1111) begin
            n_fail++;
            $display("FAIL fs_accept_repeat got %h want 1111", cap1);
        end
        n_checks++;
        if (cap2 !== 16'h2222) begin
            n_fail++;
            $display("FAIL fs_accept_next got %h want 2222", cap2);
        end
    endtask

    task automatic test_reset_mid();
        int first = -1;
        do_reset();
        sample_in = 16'hBEEF; sample_valid = 1'b1;
        while (k < 2 * D + 2 * D * 40) begin
            step();
            sample_valid = 1'b0;
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                if (n_fail <= 40) $display("FAIL pre_reset k=%0d got %b want %b", k, dut_vec, exp_vec);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({i2s_bclk, i2s_lrclk, i2s_dacdat, sample_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL mid_reset_async got %b want 0001 (bclk,lr,dat,rdy)",
                     {i2s_bclk, i2s_lrclk, i2s_dacdat, sample_ready});
        end
        do_reset();
        for (int i = 0; i < 40 && first < 0; i++) begin
            step();
            if (frame_start === 1'b1) first = k;
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                if (n_fail <= 40) $display("FAIL post_reset k=%0d got %b want %b", k, dut_vec, exp_vec);
            end
        end
        n_checks++;
        if (first != 2 * D) begin
            n_fail++;
            $display("FAIL first_frame_after_reset got clk %0d want %0d", first, 2 * D);
        end
    endtask

    task automatic test_random();
        int rate[6] = '{1, 0, 3, 50, 100, 0};
        do_reset();
        while (k < 6 * FCLK) begin
            sample_in    = 16'($urandom());
            sample_valid = ($urandom_range(0, 99) < rate[k / FCLK]);
            step();
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                if (n_fail <= 40) $display("FAIL random k=%0d got %b want %b", k, dut_vec, exp_vec);
            end
        end
    endtask

`ifdef I2S_DAC_TX_FIFO_EN
    task automatic test_fifo_fill();
        do_reset();
        while (k < 6 * FCLK) begin
            sample_valid = (k >= 10 && k < 15);
            sample_in    = 16'(16'h0100 + k);
            step();
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                if (n_fail <= 40) $display("FAIL fifo k=%0d got %b want %b", k, dut_vec, exp_vec);
            end
            if (k == 15) begin
                n_checks++;
                if (fifo_level !== 3'd4 || sample_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fifo_full got level=%0d rdy=%b want level=4 rdy=0",
                             fifo_level, sample_ready);
                end
            end
        end
    endtask
`endif

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_idle();
        test_first_sample();
        test_back_to_back();
        test_starve();
        test_fs_accept();
        test_reset_mid();
        test_random();
`ifdef I2S_DAC_TX_FIFO_EN
        test_fifo_fill();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
